// File: rtl/bm_pkg.sv
// bm_pkg: shared fetch FSM states and work-unit sizing for the mining core path
package bm_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, LAUNCH, DRAIN, HOLD} fetch_state_t;
  localparam int WORK_WORDS = 24;
  localparam int WORK_BYTES = 96;
endpackage

// File: rtl/work_fetch_unpacker.sv
// work_fetch_unpacker: bursts one work unit from the read master and unpacks it into midstate/header
module work_fetch_unpacker
  import bm_pkg::*;
#(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int MID_WORDS    = 8,
  parameter int HEAD_WORDS   = 16
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            fetch_req,
  input  logic [ADDRESSWIDTH-1:0]         fetch_base,
  output logic                            ctl_fixed_location,
  output logic [ADDRESSWIDTH-1:0]         ctl_read_base,
  output logic [ADDRESSWIDTH-1:0]         ctl_read_length,
  output logic                            ctl_go,
  input  logic                            ctl_done,
  output logic                            usr_read_buffer,
  input  logic [DATAWIDTH-1:0]            usr_buffer_data,
  input  logic                            usr_data_available,
  output logic [MID_WORDS*DATAWIDTH-1:0]  mid_state,
  output logic [HEAD_WORDS*DATAWIDTH-1:0] head_data,
  output logic                            work_valid,
  input  logic                            work_ack,
  output logic                            busy,
  output logic                            err_short
);
  fetch_state_t state, state_nxt;
  logic [4:0] cnt;
  logic [DATAWIDTH-1:0] words [WORK_WORDS];
  logic pop, last;
  assign pop = (state == FLUSH || state == DRAIN) && usr_data_available;
  assign last = cnt == 5'(WORK_WORDS - 1);
  assign usr_read_buffer = pop;
  assign ctl_fixed_location = 1'b0;
  assign ctl_read_length = ADDRESSWIDTH'(WORK_BYTES);
  assign ctl_go = state == LAUNCH;
  assign work_valid = state == HOLD;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = fetch_req ? FLUSH : IDLE;
      FLUSH:   state_nxt = usr_data_available ? FLUSH : LAUNCH;
      LAUNCH:  state_nxt = DRAIN;
      DRAIN:   state_nxt = (pop && last) ? HOLD : (!pop && ctl_done) ? IDLE : DRAIN;
      HOLD:    state_nxt = work_ack ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  // A pop in DRAIN wins over the short-burst check, so err only fires once the buffer is dry
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      ctl_read_base <= '0;
      err_short <= 1'b0;
      for (int k = 0; k < WORK_WORDS; k++) words[k] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fetch_req) ctl_read_base <= fetch_base;
      if (state == LAUNCH) cnt <= '0;
      else if (state == DRAIN && pop) begin
        words[cnt] <= usr_buffer_data;
        cnt <= cnt + 5'd1;
      end
      if (state == DRAIN && !pop && ctl_done) err_short <= 1'b1;
    end
  end
  for (genvar i = 0; i < MID_WORDS; i++) begin : g_mid
    assign mid_state[(MID_WORDS-i)*DATAWIDTH-1 -: DATAWIDTH] = words[i];
  end
  for (genvar i = 0; i < HEAD_WORDS; i++) begin : g_head
    assign head_data[(HEAD_WORDS-i)*DATAWIDTH-1 -: DATAWIDTH] = words[MID_WORDS+i];
  end
endmodule
